regfile_dual_write: RTL and testbench

Parametrised register file with two write ports, four asynchronous read ports, a hard-wired zero register, configurable write-to-read bypass and a per-register pending (scoreboard) bit. It replaces the fixed 8×32 dual-write register set in the datapath. It feeds the operand-fetch stage and accepts results from both writeback lanes. The pending bits let issue logic stall on RAW hazards without an external scoreboard.

---
 rtl/regfile_dual_write.sv | 134 +++++++++++++
 tb/tb_regfile_dual_write.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dual_write.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dual_write
// Description : Parametrised register file with two write lanes, four
//               asynchronous read ports, a hard-wired zero register,
//               optional same-cycle write-to-read bypass and a per-register
//               pending (busy) bit for RAW-hazard stalling at issue.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low; clears storage and busy
//   we1/waddr1/wdata1   write lane 1 (older)
//   we2/waddr2/wdata2   write lane 2 (younger; wins on address conflict)
//   raddr0..3/rdata0..3 combinational read ports; address 0 reads zero
//   rsv_en/rsv_addr     mark a destination register pending
//   busy                pending bit per register; busy[0] is always 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dual_write #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 8,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] raddr3,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [NUM_REGS-1:0] busy
);

  localparam int NUM_RD = 4;

  // Register 0 has no storage: the array starts at index 1.
  logic [DATA_W-1:0]   mem_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   mem_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [ADDR_W-1:0]   raddr_a [NUM_RD];
  logic [DATA_W-1:0]   rdata_a [NUM_RD];

  // --------------------------------------------------------------------------
  // Write next-state. Lane 2 is evaluated last so it overrides lane 1 when
  // both lanes target the same register.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (we1 && (waddr1 == ADDR_W'(i))) mem_d[i] = wdata1;
      if (we2 && (waddr2 == ADDR_W'(i))) mem_d[i] = wdata2;
    end
  end

  // --------------------------------------------------------------------------
  // Pending bits. A reservation beats a retiring write to the same register:
  // the reserving instruction is younger and still owes a writeback.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((we1 && (waddr1 == ADDR_W'(i))) ||
                   (we2 && (waddr2 == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Stored value is selected by a compare-mux so address 0 falls
  // through to zero without touching storage. Bypass is purely combinational
  // from the write inputs, so it remains active even while reset is low.
  // --------------------------------------------------------------------------
  assign raddr_a[0] = raddr0;
  assign raddr_a[1] = raddr1;
  assign raddr_a[2] = raddr2;
  assign raddr_a[3] = raddr3;

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rdata_a[k] = '0;
      for (int j = 1; j < NUM_REGS; j++) begin
        if (raddr_a[k] == ADDR_W'(j)) rdata_a[k] = mem_q[j];
      end
      if ((BYPASS != 0) && (raddr_a[k] != '0)) begin
        if (we2 && (waddr2 == raddr_a[k])) begin
          rdata_a[k] = wdata2;
        end else if (we1 && (waddr1 == raddr_a[k])) begin
          rdata_a[k] = wdata1;
        end
      end
    end
  end

  assign rdata0 = rdata_a[0];
  assign rdata1 = rdata_a[1];
  assign rdata2 = rdata_a[2];
  assign rdata3 = rdata_a[3];
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dual_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dual_write
// Description : Directed self-checking bench for regfile_dual_write. Drives a
//               bypass and a non-bypass 8x32 instance with shared stimulus and
//               a separate 32x64 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dual_write;

  logic clk;
  logic reset;

  // Shared 8x32 stimulus
  logic        we1, we2, rsv_en;
  logic [2:0]  waddr1, waddr2, rsv_addr;
  logic [31:0] wdata1, wdata2;
  logic [2:0]  raddr0, raddr1, raddr2, raddr3;
  logic [31:0] b_rd0, b_rd1, b_rd2, b_rd3;
  logic [31:0] n_rd0, n_rd1, n_rd2, n_rd3;
  logic [7:0]  b_busy, n_busy;

  // 32x64 stimulus
  logic        w_we1, w_we2, w_rsv_en;
  logic [4:0]  w_waddr1, w_waddr2, w_rsv_addr;
  logic [63:0] w_wdata1, w_wdata2;
  logic [4:0]  w_raddr0, w_raddr1, w_raddr2, w_raddr3;
  logic [63:0] w_rd0, w_rd1, w_rd2, w_rd3;
  logic [31:0] w_busy;

  int n_checks = 0;
  int n_errors = 0;

  regfile_dual_write #(.DATA_W(32), .NUM_REGS(8), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .rdata0(b_rd0), .rdata1(b_rd1), .rdata2(b_rd2), .rdata3(b_rd3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(b_busy)
  );

  regfile_dual_write #(.DATA_W(32), .NUM_REGS(8), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .rdata0(n_rd0), .rdata1(n_rd1), .rdata2(n_rd2), .rdata3(n_rd3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(n_busy)
  );

  regfile_dual_write #(.DATA_W(64), .NUM_REGS(32), .BYPASS(1)) u_wide (
    .clk(clk), .reset(reset),
    .we1(w_we1), .waddr1(w_waddr1), .wdata1(w_wdata1),
    .we2(w_we2), .waddr2(w_waddr2), .wdata2(w_wdata2),
    .raddr0(w_raddr0), .raddr1(w_raddr1), .raddr2(w_raddr2), .raddr3(w_raddr3),
    .rdata0(w_rd0), .rdata1(w_rd1), .rdata2(w_rd2), .rdata3(w_rd3),
    .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    w_we1 = 1'b0; w_waddr1 = '0; w_wdata1 = '0;
    w_we2 = 1'b0; w_waddr2 = '0; w_wdata2 = '0;
    w_rsv_en = 1'b0; w_rsv_addr = '0;
  endtask

  // Drive point: just after the falling edge. Sample points: #1 after drive
  // (combinational view) and #1 after the rising edge (registered view).
  task automatic to_drive();
    @(negedge clk);
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    raddr0 = 3'd1; raddr1 = 3'd2; raddr2 = 3'd3; raddr3 = 3'd7;
    w_raddr0 = 5'd31; w_raddr1 = 5'd30; w_raddr2 = 5'd0; w_raddr3 = 5'd1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd0",  {32'h0, n_rd0}, 64'h0);
    check("rst_busy", {56'h0, b_busy}, 64'h0);
    check("rst_wide_busy", {32'h0, w_busy}, 64'h0);

    to_drive();
    reset = 1'b1;

    // Load regs 1..7 with 0xA5A5_0000+i, then reserve r1, r3, r6.
    for (int i = 1; i < 8; i++) begin
      to_drive();
      idle();
      we1 = 1'b1; waddr1 = 3'(i); wdata1 = 32'hA5A5_0000 + 32'(i);
    end
    to_drive();
    idle(); rsv_en = 1'b1; rsv_addr = 3'd1;
    to_drive();
    idle(); rsv_en = 1'b1; rsv_addr = 3'd3;
    to_drive();
    idle(); rsv_en = 1'b1; rsv_addr = 3'd6;
    to_edge();
    check("load_r7",   {32'h0, n_rd3}, 64'hA5A5_0007);
    check("load_r1",   {32'h0, n_rd0}, 64'hA5A5_0001);
    check("load_busy", {56'h0, n_busy}, 64'h4A);

    // Mid-cycle asynchronous reset, no clock edge in between.
    idle();
    to_drive();
    #2;
    reset = 1'b0;
    #1;
    check("arst_rd0",  {32'h0, n_rd0}, 64'h0);
    check("arst_rd1",  {32'h0, b_rd1}, 64'h0);
    check("arst_rd2",  {32'h0, b_rd2}, 64'h0);
    check("arst_rd3",  {32'h0, n_rd3}, 64'h0);
    check("arst_busy", {56'h0, b_busy}, 64'h0);
    to_drive();
    reset = 1'b1;

    // Dual write, distinct addresses.
    to_drive();
    we1 = 1'b1; waddr1 = 3'd3; wdata1 = 32'h1111_1111;
    we2 = 1'b1; waddr2 = 3'd5; wdata2 = 32'h2222_2222;
    raddr0 = 3'd3; raddr1 = 3'd5;
    #1;
    check("dual_byp_r3",   {32'h0, b_rd0}, 64'h1111_1111);
    check("dual_byp_r5",   {32'h0, b_rd1}, 64'h2222_2222);
    check("dual_nobyp_r3", {32'h0, n_rd0}, 64'h0);
    to_edge();
    idle();
    check("dual_r3", {32'h0, n_rd0}, 64'h1111_1111);
    check("dual_r5", {32'h0, n_rd1}, 64'h2222_2222);

    // Write conflict on r4: lane 2 wins, in storage and in bypass.
    to_drive();
    we1 = 1'b1; waddr1 = 3'd4; wdata1 = 32'hDEAD_0001;
    we2 = 1'b1; waddr2 = 3'd4; wdata2 = 32'hBEEF_0002;
    raddr0 = 3'd4;
    #1;
    check("conf_byp",   {32'h0, b_rd0}, 64'hBEEF_0002);
    check("conf_nobyp", {32'h0, n_rd0}, 64'h0);
    to_edge();
    idle();
    check("conf_r4",    {32'h0, n_rd0}, 64'hBEEF_0002);
    check("conf_r4_b",  {32'h0, b_rd0}, 64'hBEEF_0002);

    // Zero register: write and reserve r0 have no effect.
    to_drive();
    we1 = 1'b1; waddr1 = 3'd0; wdata1 = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 3'd0;
    raddr0 = 3'd0;
    #1;
    check("zero_byp", {32'h0, b_rd0}, 64'h0);
    to_edge();
    idle();
    check("zero_rd",   {32'h0, b_rd0}, 64'h0);
    check("zero_busy", {56'h0, b_busy}, 64'h0);

    // Non-bypass build: r6 write appears only after the edge.
    to_drive();
    we1 = 1'b1; waddr1 = 3'd6; wdata1 = 32'h6666_6666;
    raddr2 = 3'd6;
    #1;
    check("r6_nobyp_same", {32'h0, n_rd2}, 64'h0);
    check("r6_byp_same",   {32'h0, b_rd2}, 64'h6666_6666);
    to_edge();
    idle();
    check("r6_nobyp_next", {32'h0, n_rd2}, 64'h6666_6666);

    // Scoreboard sequence on r2.
    raddr1 = 3'd2;
    to_drive();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    to_edge();
    idle();
    check("sb_set", {56'h0, b_busy}, 64'h04);
    to_drive();
    we1 = 1'b1; waddr1 = 3'd2; wdata1 = 32'h1234_5678;
    rsv_en = 1'b1; rsv_addr = 3'd2;
    to_edge();
    idle();
    check("sb_setwins", {56'h0, n_busy}, 64'h04);
    check("sb_r2_upd",  {32'h0, n_rd1}, 64'h1234_5678);
    to_drive();
    we1 = 1'b1; waddr1 = 3'd2; wdata1 = 32'h9ABC_DEF0;
    #1;
    check("sb_before_clr", {56'h0, b_busy}, 64'h04);
    to_edge();
    idle();
    check("sb_clr",    {56'h0, b_busy}, 64'h00);
    check("sb_r2_fin", {32'h0, n_rd1}, 64'h9ABC_DEF0);

    // Lane 2 retiring write clears a reservation; an unrelated reserve holds.
    to_drive();
    rsv_en = 1'b1; rsv_addr = 3'd7;
    to_drive();
    idle();
    we2 = 1'b1; waddr2 = 3'd7; wdata2 = 32'h7777_0007;
    rsv_en = 1'b1; rsv_addr = 3'd1;
    to_edge();
    idle();
    check("sb_l2_clr", {56'h0, n_busy}, 64'h02);
    check("sb_l2_r7",  {32'h0, n_rd3}, 64'h7777_0007);

    // Wide build: 64-bit data, 32 registers, 32-bit busy.
    to_drive();
    w_we1 = 1'b1; w_waddr1 = 5'd31; w_wdata1 = 64'h0123_4567_89AB_CDEF;
    w_rsv_en = 1'b1; w_rsv_addr = 5'd30;
    to_edge();
    idle();
    check("wide_r31",  w_rd0, 64'h0123_4567_89AB_CDEF);
    check("wide_busy", {32'h0, w_busy}, 64'h4000_0000);
    to_drive();
    w_we2 = 1'b1; w_waddr2 = 5'd30; w_wdata2 = 64'hFEDC_BA98_7654_3210;
    w_rsv_en = 1'b1; w_rsv_addr = 5'd31;
    #1;
    check("wide_byp_r30", w_rd1, 64'hFEDC_BA98_7654_3210);
    to_edge();
    idle();
    check("wide_r30",   w_rd1, 64'hFEDC_BA98_7654_3210);
    check("wide_busy2", {32'h0, w_busy}, 64'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
